// File: rtl/fp_mul_flag_pipe.sv
// Two-stage special-case and rounding-flag generator for the FP multiplier.
// Operand classes and rounding terms are registered in stage 1, combined product flags in stage 2.
module fp_mul_flag_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXP_W-1:0]   a_exp,
  input  logic [MAN_W-1:0]   a_man,
  input  logic [EXP_W-1:0]   b_exp,
  input  logic [MAN_W-1:0]   b_man,
  input  logic               p_sign,
  input  logic [EXP_W+1:0]   p_exp,
  input  logic [MAN_W-1:0]   p_man,
  input  logic [MAN_W:0]     p_rbits,
  input  logic [1:0]         rnd_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_cls,
  output logic [3:0]         out_rnd,
  output logic               out_inexact,
  input  logic               sticky_clr,
  output logic [4:0]         sticky_flags
);

  // Operand class as {nan, inf, zero, dnf}.
  function automatic logic [3:0] classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    logic e_zero;
    logic e_ones;
    logic m_zero;
    e_zero = (e == '0);
    e_ones = &e;
    m_zero = (m == '0);
    classify = {e_ones & ~m_zero, e_ones & m_zero, e_zero & m_zero, e_zero & ~m_zero};
  endfunction

  logic       w_s1_load;
  logic       w_s2_load;
  logic       w_hs;
  logic [3:0] w_a_cls;
  logic [3:0] w_b_cls;
  logic       w_guard;
  logic       w_sticky;
  logic       w_inexact;
  logic       w_round_inc;
  logic       w_all_ones;
  logic       w_uf;
  logic       w_of;
  logic [3:0] w_cls;
  logic [4:0] w_sticky_set;

  logic       r_s1_valid;
  logic [3:0] r_s1_a_cls;
  logic [3:0] r_s1_b_cls;
  logic [3:0] r_s1_rnd;
  logic       r_s1_inexact;

  assign w_s2_load = ~out_valid | out_ready;
  assign w_s1_load = ~r_s1_valid | w_s2_load;
  assign in_ready  = w_s1_load & ~Rst;
  assign w_hs      = out_valid & out_ready;

  assign w_a_cls    = classify(a_exp, a_man);
  assign w_b_cls    = classify(b_exp, b_man);
  assign w_guard    = p_rbits[MAN_W];
  assign w_sticky   = |p_rbits[MAN_W-1:0];
  assign w_inexact  = w_guard | w_sticky;
  assign w_all_ones = &p_man;
  assign w_uf       = p_exp[EXP_W+1];
  assign w_of       = ~p_exp[EXP_W+1] & (p_exp[EXP_W] | (&p_exp[EXP_W-1:0]));

  always_comb begin
    w_round_inc = 1'b0;
    case (rnd_mode)
      2'b00:   w_round_inc = w_guard & (p_man[0] | w_sticky);
      2'b01:   w_round_inc = 1'b0;
      2'b10:   w_round_inc = ~p_sign & w_inexact;
      2'b11:   w_round_inc = p_sign & w_inexact;
      default: w_round_inc = 1'b0;
    endcase
  end

  // Product class bits are independent; an invalid 0*inf raises nan without also raising inf or zero.
  always_comb begin
    w_cls    = 4'b0000;
    w_cls[3] = r_s1_a_cls[3] | r_s1_b_cls[3] | (r_s1_a_cls[2] & r_s1_b_cls[1]) | (r_s1_a_cls[1] & r_s1_b_cls[2]);
    w_cls[2] = (r_s1_a_cls[2] & ~(r_s1_b_cls[3] | r_s1_b_cls[1])) | (r_s1_b_cls[2] & ~(r_s1_a_cls[3] | r_s1_a_cls[1]));
    w_cls[1] = (r_s1_a_cls[1] & ~(r_s1_b_cls[3] | r_s1_b_cls[2])) | (r_s1_b_cls[1] & ~(r_s1_a_cls[3] | r_s1_a_cls[2]));
    w_cls[0] = r_s1_a_cls[0] | r_s1_b_cls[0];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_a_cls   <= 4'b0000;
      r_s1_b_cls   <= 4'b0000;
      r_s1_rnd     <= 4'b0000;
      r_s1_inexact <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a_cls   <= w_a_cls;
        r_s1_b_cls   <= w_b_cls;
        r_s1_rnd     <= {w_round_inc, w_all_ones, w_uf, w_of};
        r_s1_inexact <= w_inexact;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_valid   <= 1'b0;
      out_cls     <= 4'b0000;
      out_rnd     <= 4'b0000;
      out_inexact <= 1'b0;
    end else if (w_s2_load) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_cls     <= w_cls;
        out_rnd     <= r_s1_rnd;
        out_inexact <= r_s1_inexact;
      end
    end
  end

  assign w_sticky_set = {out_cls[3], out_rnd[0], out_rnd[1], out_inexact, out_cls[0]};

  // A clear coinciding with a handshake leaves exactly that handshake's flags.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sticky_flags <= 5'b00000;
    end else if (sticky_clr) begin
      sticky_flags <= w_hs ? w_sticky_set : 5'b00000;
    end else if (w_hs) begin
      sticky_flags <= sticky_flags | w_sticky_set;
    end
  end

endmodule

// File: tb/tb_fp_mul_flag_pipe.sv
// Directed self-checking bench for fp_mul_flag_pipe with hand-computed expectations.
module tb_fp_mul_flag_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic             Clk;
  logic             Rst;
  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] a_exp;
  logic [MAN_W-1:0] a_man;
  logic [EXP_W-1:0] b_exp;
  logic [MAN_W-1:0] b_man;
  logic             p_sign;
  logic [EXP_W+1:0] p_exp;
  logic [MAN_W-1:0] p_man;
  logic [MAN_W:0]   p_rbits;
  logic [1:0]       rnd_mode;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_cls;
  logic [3:0]       out_rnd;
  logic             out_inexact;
  logic             sticky_clr;
  logic [4:0]       sticky_flags;

  int checks   = 0;
  int failures = 0;
  int idx_in;
  int idx_out;
  logic acc;
  logic [7:0] s_sig [5];

  fp_mul_flag_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_exp(a_exp), .a_man(a_man), .b_exp(b_exp), .b_man(b_man),
    .p_sign(p_sign), .p_exp(p_exp), .p_man(p_man), .p_rbits(p_rbits),
    .rnd_mode(rnd_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_cls(out_cls), .out_rnd(out_rnd), .out_inexact(out_inexact),
    .sticky_clr(sticky_clr), .sticky_flags(sticky_flags)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] ae, input logic [22:0] am, input logic [7:0] be,
                       input logic [22:0] bm, input logic sg, input logic [9:0] pe,
                       input logic [22:0] pm, input logic [23:0] pr, input logic [1:0] rm);
    a_exp = ae; a_man = am; b_exp = be; b_man = bm;
    p_sign = sg; p_exp = pe; p_man = pm; p_rbits = pr; rnd_mode = rm;
  endtask

  // Single op with out_ready high: accept, 2-cycle latency, one-cycle output, then idle.
  task automatic run_op(input string tag, input logic [7:0] ae, input logic [22:0] am,
                        input logic [7:0] be, input logic [22:0] bm, input logic sg,
                        input logic [9:0] pe, input logic [22:0] pm, input logic [23:0] pr,
                        input logic [1:0] rm, input logic [3:0] ecls, input logic [3:0] ernd,
                        input logic einx, input logic clr);
    @(negedge Clk);
    drive(ae, am, be, bm, sg, pe, pm, pr, rm);
    in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(negedge Clk);
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, out_valid, 0);
    @(negedge Clk);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_cls"}, out_cls, ecls);
    chk({tag, "_rnd"}, out_rnd, ernd);
    chk({tag, "_inexact"}, out_inexact, einx);
    sticky_clr = clr;
    @(negedge Clk);
    sticky_clr = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 0);
  endtask

  task automatic drive_stream(input int k);
    case (k)
      0:       drive(8'h7F, 23'h0, 8'h80, 23'h0, 1'b0, 10'h080, 23'h0, 24'h0, 2'b00);
      1:       drive(8'h7F, 23'h0, 8'h80, 23'h0, 1'b0, 10'h0FF, 23'h0, 24'h0, 2'b00);
      2:       drive(8'h7F, 23'h0, 8'h80, 23'h0, 1'b0, 10'h2FE, 23'h0, 24'h0, 2'b00);
      3:       drive(8'h7F, 23'h0, 8'h80, 23'h0, 1'b0, 10'h080, 23'h7FFFFF, 24'h0, 2'b00);
      default: drive(8'hFF, 23'h0, 8'h80, 23'h0, 1'b0, 10'h080, 23'h0, 24'h0, 2'b00);
    endcase
  endtask

  initial begin
    s_sig[0] = 8'b0000_0000;
    s_sig[1] = 8'b0000_0001;
    s_sig[2] = 8'b0000_0010;
    s_sig[3] = 8'b0000_0100;
    s_sig[4] = 8'b0100_0000;

    Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
    drive(8'h7F, 23'h0, 8'h80, 23'h0, 1'b0, 10'h080, 23'h0, 24'h0, 2'b00);
    repeat (3) @(negedge Clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cls_rnd", {out_cls, out_rnd, out_inexact}, 0);
    chk("rst_sticky", sticky_flags, 0);
    Rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    run_op("normal", 8'h7F, 23'h0, 8'h80, 23'h0, 1'b0, 10'h080, 23'h0, 24'h0, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("normal_sticky", sticky_flags, 5'b00000);
    run_op("inf_x_zero", 8'hFF, 23'h0, 8'h00, 23'h0, 1'b0, 10'h080, 23'h0, 24'h0, 2'b00, 4'b1000, 4'b0000, 1'b0, 1'b0);
    chk("inf_x_zero_sticky", sticky_flags, 5'b10000);
    run_op("zero_x_inf", 8'h00, 23'h0, 8'hFF, 23'h0, 1'b0, 10'h080, 23'h0, 24'h0, 2'b00, 4'b1000, 4'b0000, 1'b0, 1'b0);
    chk("zero_x_inf_sticky", sticky_flags, 5'b10000);
    @(negedge Clk); sticky_clr = 1'b1;
    @(negedge Clk); sticky_clr = 1'b0;
    chk("clr_sticky", sticky_flags, 5'b00000);

    run_op("rne_lsb1",  8'h7F, 23'h0, 8'h80, 23'h0, 1'b0, 10'h080, 23'h1, 24'h800000, 2'b00, 4'b0000, 4'b1000, 1'b1, 1'b0);
    run_op("rne_tie0",  8'h7F, 23'h0, 8'h80, 23'h0, 1'b0, 10'h080, 23'h0, 24'h800000, 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b0);
    run_op("rtz",       8'h7F, 23'h0, 8'h80, 23'h0, 1'b0, 10'h080, 23'h1, 24'h800000, 2'b01, 4'b0000, 4'b0000, 1'b1, 1'b0);
    run_op("rup_pos",   8'h7F, 23'h0, 8'h80, 23'h0, 1'b0, 10'h080, 23'h1, 24'h800000, 2'b10, 4'b0000, 4'b1000, 1'b1, 1'b0);
    run_op("rdn_pos",   8'h7F, 23'h0, 8'h80, 23'h0, 1'b0, 10'h080, 23'h1, 24'h800000, 2'b11, 4'b0000, 4'b0000, 1'b1, 1'b0);
    run_op("rdn_neg",   8'h7F, 23'h0, 8'h80, 23'h0, 1'b1, 10'h080, 23'h1, 24'h800000, 2'b11, 4'b0000, 4'b1000, 1'b1, 1'b0);
    run_op("sticky_only", 8'h7F, 23'h0, 8'h80, 23'h0, 1'b0, 10'h080, 23'h0, 24'h000001, 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b0);
    chk("round_sticky", sticky_flags, 5'b00010);

    run_op("of_0ff",   8'h7F, 23'h0, 8'h80, 23'h0, 1'b0, 10'h0FF, 23'h0, 24'h0, 2'b00, 4'b0000, 4'b0001, 1'b0, 1'b0);
    run_op("of_100",   8'h7F, 23'h0, 8'h80, 23'h0, 1'b0, 10'h100, 23'h0, 24'h0, 2'b00, 4'b0000, 4'b0001, 1'b0, 1'b0);
    run_op("uf_2fe",   8'h7F, 23'h0, 8'h80, 23'h0, 1'b0, 10'h2FE, 23'h0, 24'h0, 2'b00, 4'b0000, 4'b0010, 1'b0, 1'b0);
    run_op("all_ones", 8'h7F, 23'h0, 8'h80, 23'h0, 1'b0, 10'h080, 23'h7FFFFF, 24'h0, 2'b00, 4'b0000, 4'b0100, 1'b0, 1'b0);
    chk("ofuf_sticky", sticky_flags, 5'b01110);
    run_op("dnf", 8'h00, 23'h1, 8'h80, 23'h0, 1'b0, 10'h080, 23'h0, 24'h0, 2'b00, 4'b0001, 4'b0000, 1'b0, 1'b0);
    chk("dnf_sticky", sticky_flags, 5'b01111);

    // Back-pressure: out_ready low for the first 4 cycles of a 5-op stream.
    idx_in = 0;
    idx_out = 0;
    for (int cyc = 0; cyc < 40 && idx_out < 5; cyc++) begin
      @(negedge Clk);
      out_ready = (cyc >= 4);
      if (idx_in < 5) begin
        drive_stream(idx_in);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 2 || cyc == 3) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_accepts", idx_in, 2);
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_data", {out_cls, out_rnd}, s_sig[0]);
      end
      acc = in_valid & in_ready;
      if (out_valid & out_ready) begin
        chk("stream_order", {out_cls, out_rnd}, s_sig[idx_out]);
        idx_out++;
      end
      @(posedge Clk);
      if (acc) idx_in++;
    end
    in_valid = 1'b0;
    chk("stream_count", idx_out, 5);
    @(negedge Clk);
    chk("stream_no_dup", out_valid, 0);

    // Reset with two ops in flight.
    @(negedge Clk); drive_stream(0); in_valid = 1'b1;
    @(negedge Clk); drive_stream(1);
    @(negedge Clk); in_valid = 1'b0;
    chk("pre_rst_sticky", sticky_flags, 5'b01111);
    chk("pre_rst_valid", out_valid, 1);
    Rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", in_ready, 0);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_sticky", sticky_flags, 5'b00000);
    chk("rst_mid_in_ready_after", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("rst_mid_flushed", out_valid, 0);
    end

    run_op("nan_op", 8'hFF, 23'h5, 8'h80, 23'h0, 1'b0, 10'h080, 23'h0, 24'h0, 2'b00, 4'b1000, 4'b0000, 1'b0, 1'b0);
    chk("nan_op_sticky", sticky_flags, 5'b10000);
    run_op("clr_hs", 8'h7F, 23'h0, 8'h80, 23'h0, 1'b0, 10'h080, 23'h1, 24'h800000, 2'b01, 4'b0000, 4'b0000, 1'b1, 1'b1);
    chk("clr_hs_sticky", sticky_flags, 5'b00010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
